// File: rtl/mac_sched.sv
// mac_sched: round-robin front end that shares one signed 16x16 / dual 8x8 MAC
// among NREQ valid/ready requesters. It locks the MAC to a requester for the
// length of its accumulate chain and routes each MAC result back by tag.
module mac_sched #(
  parameter int NREQ = 2,
  parameter int LAT  = 3,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [3*NREQ-1:0]        req_op,
  input  logic [16*NREQ-1:0]       req_a,
  input  logic [16*NREQ-1:0]       req_b,
  input  logic [NREQ-1:0]          req_last,
  input  logic                     hold,
  output logic [2:0]               mac_instr,
  output logic signed [15:0]       mac_a,
  output logic signed [15:0]       mac_b,
  output logic                     mac_stall,
  input  logic [39:0]              mac_data,
  output logic                     rsp_valid,
  output logic [IDW-1:0]           rsp_id,
  output logic [39:0]              rsp_data,
  output logic                     err_mode,
  output logic                     busy
);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_e;

  state_e                 state_q, state_d;
  logic [IDW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]         owner_q, owner_d;
  logic                   lock_mode_q, lock_mode_d;
  logic                   err_mode_q, err_mode_d;

  logic                   accept;
  logic [IDW-1:0]         grant_id;
  logic [2:0]             g_op;
  logic signed [15:0]     g_a, g_b;
  logic                   g_last;

  logic [2:0]             mac_instr_q, mac_instr_d;
  logic signed [15:0]     mac_a_q, mac_a_d;
  logic signed [15:0]     mac_b_q, mac_b_d;
  logic                   mac_stall_q, mac_stall_d;

  // The tag pipe is one stage longer than LAT so that its last stage becomes
  // valid on the same edge the matching result appears on mac_data.
  logic [LAT:0]           tag_vld_q, tag_vld_d;
  logic [IDW-1:0]         tag_id_q [LAT+1];
  logic [IDW-1:0]         tag_id_d [LAT+1];

  logic                   rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]         rsp_id_q, rsp_id_d;
  logic [39:0]            rsp_data_q, rsp_data_d;

  // Grant search: first valid requester at or after rr_ptr, overridden by the lock owner.
  always_comb begin
    logic [IDW:0] sum;
    logic [IDW-1:0] idx;
    accept   = 1'b0;
    grant_id = '0;
    sum      = '0;
    idx      = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, rr_ptr_q} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
      idx = sum[IDW-1:0];
      if (!accept && req_valid[idx]) begin
        accept   = 1'b1;
        grant_id = idx;
      end
    end
    if (state_q == LOCKED) begin
      accept   = req_valid[owner_q];
      grant_id = owner_q;
    end
    if (hold || !reset_n) accept = 1'b0;
  end

  // Select the grantee's beat fields.
  always_comb begin
    g_op   = '0;
    g_a    = '0;
    g_b    = '0;
    g_last = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant_id == IDW'(k)) begin
        g_op   = req_op[3*k +: 3];
        g_a    = req_a[16*k +: 16];
        g_b    = req_b[16*k +: 16];
        g_last = req_last[k];
      end
    end
  end

  // One-hot ready for the accepted requester only.
  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant_id] = 1'b1;
  end

  // Lock FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Lock FSM next state: a chain opens on a non-last beat and closes on the owner's last beat.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && !g_last) state_d = LOCKED;
      LOCKED:  if (accept && g_last)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Lock FSM outputs: owner capture, mode check and round-robin pointer advance.
  always_comb begin
    owner_d     = owner_q;
    lock_mode_d = lock_mode_q;
    err_mode_d  = 1'b0;
    rr_ptr_d    = rr_ptr_q;
    if (state_q == IDLE && accept && !g_last) begin
      owner_d     = grant_id;
      lock_mode_d = g_op[2];
    end
    if (state_q == LOCKED && accept && (g_op[2] != lock_mode_q)) err_mode_d = 1'b1;
    if (accept) rr_ptr_d = (grant_id == IDW'(NREQ-1)) ? '0 : grant_id + 1'b1;
  end

  // Issue slot: load the grantee's beat, otherwise stall and keep the old operands.
  always_comb begin
    mac_instr_d = mac_instr_q;
    mac_a_d     = mac_a_q;
    mac_b_d     = mac_b_q;
    mac_stall_d = 1'b1;
    if (accept) begin
      mac_instr_d = g_op;
      mac_a_d     = g_a;
      mac_b_d     = g_b;
      mac_stall_d = 1'b0;
    end
  end

  // Tag pipe advances every cycle, independent of stall and hold.
  always_comb begin
    tag_vld_d   = {tag_vld_q[LAT-1:0], accept};
    tag_id_d[0] = grant_id;
    for (int s = 1; s <= LAT; s++) tag_id_d[s] = tag_id_q[s-1];
  end

  // Response capture when the final tag stage carries a live slot.
  always_comb begin
    rsp_valid_d = tag_vld_q[LAT];
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    if (tag_vld_q[LAT]) begin
      rsp_id_d   = tag_id_q[LAT];
      rsp_data_d = mac_data;
    end
  end

  // Control, issue and response registers with asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      lock_mode_q <= 1'b0;
      err_mode_q  <= 1'b0;
      mac_instr_q <= '0;
      mac_a_q     <= '0;
      mac_b_q     <= '0;
      mac_stall_q <= 1'b1;
      tag_vld_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      lock_mode_q <= lock_mode_d;
      err_mode_q  <= err_mode_d;
      mac_instr_q <= mac_instr_d;
      mac_a_q     <= mac_a_d;
      mac_b_q     <= mac_b_d;
      mac_stall_q <= mac_stall_d;
      tag_vld_q   <= tag_vld_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // Tag ids are qualified by tag_vld, so they need no reset.
  always_ff @(posedge clk) begin
    for (int s = 0; s <= LAT; s++) tag_id_q[s] <= tag_id_d[s];
  end

  assign mac_instr = mac_instr_q;
  assign mac_a     = mac_a_q;
  assign mac_b     = mac_b_q;
  assign mac_stall = mac_stall_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign err_mode  = err_mode_q;
  assign busy      = (state_q == LOCKED) | (|tag_vld_q) | rsp_valid_q;

endmodule
